// File: rtl/mbc_pkg.sv
// ---------------------------------------------------------------------------
// mbc_pkg
// Shared types and constants for the multi-buffer frame ownership controller.
//   buffer_state_t  : life cycle of one frame buffer
//   channel_state_t : grant handshake state of the read and write channels
//   MAX_BUFFERS     : largest supported buffer count
//   SVL_VERBOSE_INFO: default simulation logging verbosity level
// ---------------------------------------------------------------------------
package mbc_pkg;

  localparam int MAX_BUFFERS      = 16;
  localparam int SVL_VERBOSE_INFO = 3;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } buffer_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } channel_state_t;

endpackage

// File: rtl/mbc_index_queue.sv
// ---------------------------------------------------------------------------
// mbc_index_queue
// Circular FIFO of buffer indices, holding completed frames in write order.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (pointers and count)
//   push/push_id : enqueue an index (ignored when full)
//   pop          : dequeue the head entry (ignored when empty)
//   head_id      : oldest stored index, valid while count != 0
//   count        : number of stored indices, 0..DEPTH
// ---------------------------------------------------------------------------
module mbc_index_queue
  import mbc_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic [ID_W:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ID_W:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    do_push  = push && (int'(count_q) < DEPTH);
    do_pop   = pop && (count_q != '0);
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + (ID_W+1)'(do_push) - (ID_W+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

  assign head_id = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/multi_buffer_controller.sv
// ---------------------------------------------------------------------------
// multi_buffer_controller
// Hands out frame-buffer indices to one writer and one reader, tracking the
// ownership state of NUM_BUFFERS (3..16) buffers.
//   QUEUE_MODE = 0 : mailbox, reader always gets the newest completed frame
//   QUEUE_MODE = 1 : completed frames are read in order, both sides may stall
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   write_rq_rdy / finalize_wr    : writer request level / completion pulse
//   write_id_valid / write_id     : write grant
//   read_rq_rdy / finalize_rd     : reader request level / release pulse
//   read_id_valid / read_id       : read grant
//   ready_count                   : buffers holding a readable frame
//   frames_dropped                : saturating count of frames lost unread
//   protocol_err                  : pulse when a finalize arrives unowned
// ---------------------------------------------------------------------------
module multi_buffer_controller
  import mbc_pkg::*;
#(
  parameter  int NUM_BUFFERS = 3,
  parameter  int QUEUE_MODE  = 0,
  parameter  int CNT_W       = 16,
  parameter  int LOG_LEVEL   = SVL_VERBOSE_INFO,
  localparam int ID_W        = $clog2(NUM_BUFFERS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write_rq_rdy,
  input  logic             finalize_wr,
  output logic             write_id_valid,
  output logic [ID_W-1:0]  write_id,
  input  logic             read_rq_rdy,
  input  logic             finalize_rd,
  output logic             read_id_valid,
  output logic [ID_W-1:0]  read_id,
  output logic [ID_W:0]    ready_count,
  output logic [CNT_W-1:0] frames_dropped,
  output logic             protocol_err
);

  localparam bit IS_QUEUE         = (QUEUE_MODE != 0);
  localparam int unused_log_level = LOG_LEVEL;

  buffer_state_t   buf_q [NUM_BUFFERS];
  buffer_state_t   buf_d [NUM_BUFFERS];
  logic [ID_W-1:0] latest_q, latest_d;
  logic            latest_fresh_q, latest_fresh_d;  // latest holds a written, unread frame
  logic [ID_W-1:0] last_wr_q, last_wr_d;
  logic [ID_W-1:0] wr_id_q, wr_id_d;
  logic [ID_W-1:0] rd_id_q, rd_id_d;
  logic            wr_own_q, wr_own_d;
  logic            rd_own_q, rd_own_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;
  logic            err_q, err_d;
  channel_state_t  wr_ch_q, wr_ch_d;
  channel_state_t  rd_ch_q, rd_ch_d;

  logic            wr_grant, rd_grant;
  logic            wr_found;
  logic [ID_W-1:0] wr_cand;
  int              wr_idx;
  logic [1:0]      drop_inc;
  logic [ID_W:0]   ready_cnt;

  logic            q_push, q_pop;
  logic [ID_W-1:0] q_push_id, q_head;
  logic [ID_W:0]   q_count;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Mailbox mode may overwrite an older completed frame; queue mode may not.
  function automatic logic write_eligible(input buffer_state_t st, input logic is_latest);
    if (st == FREE) return 1'b1;
    return !IS_QUEUE && (st == READY) && !is_latest;
  endfunction

  if (IS_QUEUE) begin : g_queue
    mbc_index_queue #(
      .DEPTH (NUM_BUFFERS),
      .ID_W  (ID_W)
    ) u_queue (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (q_push),
      .push_id (q_push_id),
      .pop     (q_pop),
      .head_id (q_head),
      .count   (q_count)
    );
  end else begin : g_mailbox
    logic unused_queue_ctl;
    assign unused_queue_ctl = ^{q_push, q_pop, q_push_id};
    assign q_head  = '0;
    assign q_count = '0;
  end

  // Ownership datapath: finalizes are applied first so that a same-cycle
  // request sees the buffer they produce or release.
  always_comb begin
    buf_d          = buf_q;
    latest_d       = latest_q;
    latest_fresh_d = latest_fresh_q;
    last_wr_d      = last_wr_q;
    wr_id_d        = wr_id_q;
    rd_id_d        = rd_id_q;
    wr_own_d       = wr_own_q;
    rd_own_d       = rd_own_q;
    err_d          = 1'b0;
    drop_inc       = 2'd0;
    wr_grant       = 1'b0;
    rd_grant       = 1'b0;
    wr_found       = 1'b0;
    wr_cand        = '0;
    wr_idx         = 0;
    q_push         = 1'b0;
    q_pop          = 1'b0;
    q_push_id      = wr_id_q;

    if (finalize_wr) begin
      if (wr_own_q) begin
        buf_d[wr_id_q] = READY;
        wr_own_d       = 1'b0;
        if (IS_QUEUE) begin
          q_push = 1'b1;
        end else begin
          // A previous latest still being read stays with the reader.
          if (buf_q[latest_q] == READY) begin
            buf_d[latest_q] = FREE;
            if (latest_fresh_q) drop_inc = drop_inc + 2'd1;
          end
          latest_d       = wr_id_q;
          latest_fresh_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (finalize_rd) begin
      if (rd_own_q) begin
        rd_own_d       = 1'b0;
        buf_d[rd_id_q] = (!IS_QUEUE && (rd_id_q == latest_d)) ? READY : FREE;
      end else begin
        err_d = 1'b1;
      end
    end

    if ((wr_ch_q == IDLE) && write_rq_rdy) begin
      if (wr_own_d) begin
        wr_grant = 1'b1;
      end else begin
        for (int k = 1; k <= NUM_BUFFERS; k++) begin
          wr_idx = (int'(last_wr_q) + k) % NUM_BUFFERS;
          if (!wr_found && write_eligible(buf_d[wr_idx], wr_idx == int'(latest_d))) begin
            wr_found = 1'b1;
            wr_cand  = ID_W'(wr_idx);
          end
        end
        if (wr_found) begin
          if (buf_d[wr_cand] == READY) drop_inc = drop_inc + 2'd1;
          buf_d[wr_cand] = WRITING;
          wr_grant       = 1'b1;
          wr_id_d        = wr_cand;
          wr_own_d       = 1'b1;
          last_wr_d      = wr_cand;
        end
      end
    end

    if ((rd_ch_q == IDLE) && read_rq_rdy) begin
      if (rd_own_d) begin
        rd_grant = 1'b1;
      end else if (!IS_QUEUE) begin
        // With the reader owning nothing, latest is always READY here.
        buf_d[latest_d] = READING;
        rd_grant        = 1'b1;
        rd_id_d         = latest_d;
        rd_own_d        = 1'b1;
        latest_fresh_d  = 1'b0;
      end else if (q_count != '0) begin
        q_pop         = 1'b1;
        buf_d[q_head] = READING;
        rd_grant      = 1'b1;
        rd_id_d       = q_head;
        rd_own_d      = 1'b1;
      end else if (q_push) begin
        // Empty queue: hand the frame finishing this cycle straight over.
        q_push           = 1'b0;
        buf_d[q_push_id] = READING;
        rd_grant         = 1'b1;
        rd_id_d          = q_push_id;
        rd_own_d         = 1'b1;
      end
    end

    dropped_d = sat_add(dropped_q, drop_inc);
  end

  always_comb begin
    wr_ch_d = wr_ch_q;
    unique case (wr_ch_q)
      IDLE:        if (wr_grant) wr_ch_d = GRANT;
      GRANT, HOLD: wr_ch_d = write_rq_rdy ? HOLD : IDLE;
      default:     wr_ch_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ch_d = rd_ch_q;
    unique case (rd_ch_q)
      IDLE:        if (rd_grant) rd_ch_d = GRANT;
      GRANT, HOLD: rd_ch_d = read_rq_rdy ? HOLD : IDLE;
      default:     rd_ch_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        buf_q[i] <= (!IS_QUEUE && (i == 0)) ? READY : FREE;
      end
      latest_q       <= '0;
      latest_fresh_q <= 1'b0;
      last_wr_q      <= '0;
      wr_id_q        <= '0;
      rd_id_q        <= '0;
      wr_own_q       <= 1'b0;
      rd_own_q       <= 1'b0;
      dropped_q      <= '0;
      err_q          <= 1'b0;
      wr_ch_q        <= IDLE;
      rd_ch_q        <= IDLE;
    end else begin
      buf_q          <= buf_d;
      latest_q       <= latest_d;
      latest_fresh_q <= latest_fresh_d;
      last_wr_q      <= last_wr_d;
      wr_id_q        <= wr_id_d;
      rd_id_q        <= rd_id_d;
      wr_own_q       <= wr_own_d;
      rd_own_q       <= rd_own_d;
      dropped_q      <= dropped_d;
      err_q          <= err_d;
      wr_ch_q        <= wr_ch_d;
      rd_ch_q        <= rd_ch_d;
    end
  end

  always_comb begin
    ready_cnt = '0;
    if (IS_QUEUE) begin
      ready_cnt = q_count;
    end else begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (buf_q[i] == READY) ready_cnt = ready_cnt + (ID_W+1)'(1);
      end
    end
  end

  always_comb begin
    write_id_valid = (wr_ch_q != IDLE);
    write_id       = wr_id_q;
    read_id_valid  = (rd_ch_q != IDLE);
    read_id        = rd_id_q;
    ready_count    = ready_cnt;
    frames_dropped = dropped_q;
    protocol_err   = err_q;
  end

endmodule

// File: tb/tb_multi_buffer_controller.sv
// ---------------------------------------------------------------------------
// tb_multi_buffer_controller
// Directed bench over three controller instances:
//   [0] NUM_BUFFERS=3 mailbox, [1] NUM_BUFFERS=4 mailbox, [2] NUM_BUFFERS=4 queue
// ---------------------------------------------------------------------------
module tb_multi_buffer_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic        wr_rq  [3];
  logic        fin_wr [3];
  logic        rd_rq  [3];
  logic        fin_rd [3];
  logic        wr_vld [3];
  logic        rd_vld [3];
  logic        perr   [3];
  logic [1:0]  wr_id  [3];
  logic [1:0]  rd_id  [3];
  logic [2:0]  rcnt   [3];
  logic [15:0] drop   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_buffer_controller #(.NUM_BUFFERS(3), .QUEUE_MODE(0), .CNT_W(16)) dut_l3 (
    .clk(clk), .reset_n(reset_n),
    .write_rq_rdy(wr_rq[0]), .finalize_wr(fin_wr[0]),
    .write_id_valid(wr_vld[0]), .write_id(wr_id[0]),
    .read_rq_rdy(rd_rq[0]), .finalize_rd(fin_rd[0]),
    .read_id_valid(rd_vld[0]), .read_id(rd_id[0]),
    .ready_count(rcnt[0]), .frames_dropped(drop[0]), .protocol_err(perr[0]));

  multi_buffer_controller #(.NUM_BUFFERS(4), .QUEUE_MODE(0), .CNT_W(16)) dut_l4 (
    .clk(clk), .reset_n(reset_n),
    .write_rq_rdy(wr_rq[1]), .finalize_wr(fin_wr[1]),
    .write_id_valid(wr_vld[1]), .write_id(wr_id[1]),
    .read_rq_rdy(rd_rq[1]), .finalize_rd(fin_rd[1]),
    .read_id_valid(rd_vld[1]), .read_id(rd_id[1]),
    .ready_count(rcnt[1]), .frames_dropped(drop[1]), .protocol_err(perr[1]));

  multi_buffer_controller #(.NUM_BUFFERS(4), .QUEUE_MODE(1), .CNT_W(16)) dut_q4 (
    .clk(clk), .reset_n(reset_n),
    .write_rq_rdy(wr_rq[2]), .finalize_wr(fin_wr[2]),
    .write_id_valid(wr_vld[2]), .write_id(wr_id[2]),
    .read_rq_rdy(rd_rq[2]), .finalize_rd(fin_rd[2]),
    .read_id_valid(rd_vld[2]), .read_id(rd_id[2]),
    .ready_count(rcnt[2]), .frames_dropped(drop[2]), .protocol_err(perr[2]));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise the write request and wait up to max_cyc edges for the grant.
  // lat = -1 when no grant arrived; the request is left high.
  task automatic req_write(input int d, input int max_cyc, output int lat, output logic [1:0] id);
    int c;
    lat = -1; id = 2'd0; c = 0;
    wr_rq[d] = 1'b1;
    while (lat < 0 && c < max_cyc) begin
      c++;
      step(1);
      if (wr_vld[d] === 1'b1) begin lat = c; id = wr_id[d]; end
    end
  endtask

  task automatic req_read(input int d, input int max_cyc, output int lat, output logic [1:0] id);
    int c;
    lat = -1; id = 2'd0; c = 0;
    rd_rq[d] = 1'b1;
    while (lat < 0 && c < max_cyc) begin
      c++;
      step(1);
      if (rd_vld[d] === 1'b1) begin lat = c; id = rd_id[d]; end
    end
  endtask

  task automatic rel_write(input int d);
    wr_rq[d] = 1'b0; step(1);
  endtask

  task automatic rel_read(input int d);
    rd_rq[d] = 1'b0; step(1);
  endtask

  task automatic pulse_fin_wr(input int d);
    fin_wr[d] = 1'b1; step(1); fin_wr[d] = 1'b0;
  endtask

  task automatic pulse_fin_rd(input int d);
    fin_rd[d] = 1'b1; step(1); fin_rd[d] = 1'b0;
  endtask

  task automatic test_reset();
    int exp_rc [3];
    exp_rc = '{1, 1, 0};
    for (int d = 0; d < 3; d++) begin
      checks++; if (wr_vld[d] !== 1'b0) begin failures++; $display("FAIL reset_wr_vld[%0d] got=%0b exp=0", d, wr_vld[d]); end
      checks++; if (rd_vld[d] !== 1'b0) begin failures++; $display("FAIL reset_rd_vld[%0d] got=%0b exp=0", d, rd_vld[d]); end
      checks++; if (drop[d] !== 16'd0) begin failures++; $display("FAIL reset_drop[%0d] got=%0d exp=0", d, drop[d]); end
      checks++; if (perr[d] !== 1'b0) begin failures++; $display("FAIL reset_perr[%0d] got=%0b exp=0", d, perr[d]); end
      checks++; if (rcnt[d] !== 3'(exp_rc[d])) begin failures++; $display("FAIL reset_rcnt[%0d] got=%0d exp=%0d", d, rcnt[d], exp_rc[d]); end
    end
  endtask

  task automatic test_latest_rotation();
    int lat;
    logic [1:0] id;
    for (int i = 0; i < 10; i++) begin
      req_write(0, 4, lat, id);
      checks++; if (lat !== 1) begin failures++; $display("FAIL t1_wr_lat[%0d] got=%0d exp=1", i, lat); end
      checks++; if (id !== 2'((i + 1) % 3)) begin failures++; $display("FAIL t1_wr_id[%0d] got=%0d exp=%0d", i, id, (i + 1) % 3); end
      rel_write(0);
      checks++; if (wr_vld[0] !== 1'b0) begin failures++; $display("FAIL t1_wr_drop_vld[%0d] got=%0b exp=0", i, wr_vld[0]); end
      req_read(0, 4, lat, id);
      checks++; if (lat !== 1) begin failures++; $display("FAIL t1_rd_lat[%0d] got=%0d exp=1", i, lat); end
      checks++; if (id !== 2'(i % 3)) begin failures++; $display("FAIL t1_rd_id[%0d] got=%0d exp=%0d", i, id, i % 3); end
      rel_read(0);
      pulse_fin_rd(0);
      pulse_fin_wr(0);
    end
    checks++; if (drop[0] !== 16'd0) begin failures++; $display("FAIL t1_dropped got=%0d exp=0", drop[0]); end
  endtask

  task automatic test_latest_drop();
    int lat;
    logic [1:0] id;
    for (int i = 0; i < 3; i++) begin
      req_write(1, 4, lat, id);
      checks++; if (id !== 2'(i + 1) || lat !== 1) begin failures++; $display("FAIL t2_wr_id[%0d] got=%0d lat=%0d exp=%0d lat=1", i, id, lat, i + 1); end
      rel_write(1);
      pulse_fin_wr(1);
    end
    checks++; if (drop[1] !== 16'd2) begin failures++; $display("FAIL t2_dropped got=%0d exp=2", drop[1]); end
    checks++; if (rcnt[1] !== 3'd1) begin failures++; $display("FAIL t2_rcnt got=%0d exp=1", rcnt[1]); end
    req_read(1, 4, lat, id);
    checks++; if (id !== 2'd3 || lat !== 1) begin failures++; $display("FAIL t2_rd_id got=%0d lat=%0d exp=3 lat=1", id, lat); end
    rel_read(1);
    pulse_fin_rd(1);
  endtask

  task automatic test_queue_order();
    int lat;
    logic [1:0] id;
    int exp_w [4];
    exp_w = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      req_write(2, 4, lat, id);
      checks++; if (id !== 2'(exp_w[i]) || lat !== 1) begin failures++; $display("FAIL t3_wr_id[%0d] got=%0d lat=%0d exp=%0d lat=1", i, id, lat, exp_w[i]); end
      rel_write(2);
      pulse_fin_wr(2);
    end
    checks++; if (rcnt[2] !== 3'd4) begin failures++; $display("FAIL t3_rcnt_full got=%0d exp=4", rcnt[2]); end
    req_write(2, 5, lat, id);
    checks++; if (lat !== -1 || wr_vld[2] !== 1'b0) begin failures++; $display("FAIL t3_wr_stall got lat=%0d vld=%0b exp stall", lat, wr_vld[2]); end
    req_read(2, 4, lat, id);
    checks++; if (id !== 2'd1 || lat !== 1) begin failures++; $display("FAIL t3_rd0 got=%0d lat=%0d exp=1 lat=1", id, lat); end
    rel_read(2);
    checks++; if (wr_vld[2] !== 1'b0) begin failures++; $display("FAIL t3_wr_still_stalled got=%0b exp=0", wr_vld[2]); end
    pulse_fin_rd(2);
    checks++; if (wr_vld[2] !== 1'b1 || wr_id[2] !== 2'd1) begin failures++; $display("FAIL t3_wr_unstall got vld=%0b id=%0d exp vld=1 id=1", wr_vld[2], wr_id[2]); end
    rel_write(2);
    for (int i = 2; i <= 3; i++) begin
      req_read(2, 4, lat, id);
      checks++; if (id !== 2'(i) || lat !== 1) begin failures++; $display("FAIL t3_rd_order got=%0d lat=%0d exp=%0d lat=1", id, lat, i); end
      rel_read(2);
      pulse_fin_rd(2);
    end
    checks++; if (rcnt[2] !== 3'd1) begin failures++; $display("FAIL t3_rcnt_left got=%0d exp=1", rcnt[2]); end
  endtask

  task automatic test_queue_empty_read();
    int lat;
    int waited;
    logic [1:0] id;
    req_read(2, 4, lat, id);
    checks++; if (id !== 2'd0 || lat !== 1) begin failures++; $display("FAIL t4_drain got=%0d lat=%0d exp=0 lat=1", id, lat); end
    rel_read(2);
    pulse_fin_rd(2);
    checks++; if (rcnt[2] !== 3'd0) begin failures++; $display("FAIL t4_rcnt_empty got=%0d exp=0", rcnt[2]); end
    req_read(2, 4, lat, id);
    checks++; if (lat !== -1 || rd_vld[2] !== 1'b0) begin failures++; $display("FAIL t4_rd_stall got lat=%0d vld=%0b exp stall", lat, rd_vld[2]); end
    pulse_fin_wr(2);
    waited = 1;
    while (rd_vld[2] !== 1'b1 && waited < 2) begin
      step(1);
      waited++;
    end
    checks++; if (rd_vld[2] !== 1'b1 || rd_id[2] !== 2'd1) begin failures++; $display("FAIL t4_rd_grant got vld=%0b id=%0d exp vld=1 id=1", rd_vld[2], rd_id[2]); end
    rel_read(2);
    pulse_fin_rd(2);
  endtask

  task automatic test_same_cycle_and_err();
    int lat;
    logic [1:0] id;
    req_write(0, 4, lat, id);
    checks++; if (id !== 2'd2 || lat !== 1) begin failures++; $display("FAIL t5_wr_id got=%0d lat=%0d exp=2 lat=1", id, lat); end
    rel_write(0);
    fin_wr[0] = 1'b1;
    rd_rq[0]  = 1'b1;
    step(1);
    fin_wr[0] = 1'b0;
    checks++; if (rd_vld[0] !== 1'b1 || rd_id[0] !== 2'd2) begin failures++; $display("FAIL t5_rd_new_frame got vld=%0b id=%0d exp vld=1 id=2", rd_vld[0], rd_id[0]); end
    checks++; if (drop[0] !== 16'd1) begin failures++; $display("FAIL t5_dropped got=%0d exp=1", drop[0]); end
    rel_read(0);
    pulse_fin_rd(0);
    checks++; if (perr[0] !== 1'b0) begin failures++; $display("FAIL t5_no_err got=%0b exp=0", perr[0]); end
    pulse_fin_rd(0);
    checks++; if (perr[0] !== 1'b1) begin failures++; $display("FAIL t5_err_pulse got=%0b exp=1", perr[0]); end
    step(1);
    checks++; if (perr[0] !== 1'b0) begin failures++; $display("FAIL t5_err_clear got=%0b exp=0", perr[0]); end
    checks++; if (rcnt[0] !== 3'd1 || drop[0] !== 16'd1) begin failures++; $display("FAIL t5_state_kept got rcnt=%0d drop=%0d exp rcnt=1 drop=1", rcnt[0], drop[0]); end
    req_read(0, 4, lat, id);
    checks++; if (id !== 2'd2 || lat !== 1) begin failures++; $display("FAIL t5_reread got=%0d lat=%0d exp=2 lat=1", id, lat); end
    rel_read(0);
  endtask

  task automatic test_reset_mid_hold();
    int lat;
    logic [1:0] id;
    wr_rq[1] = 1'b1;
    rd_rq[1] = 1'b1;
    step(3);
    checks++; if (wr_vld[1] !== 1'b1 || rd_vld[1] !== 1'b1 || rd_id[1] !== 2'd3) begin failures++; $display("FAIL t6_hold got wv=%0b rv=%0b rid=%0d exp 1 1 3", wr_vld[1], rd_vld[1], rd_id[1]); end
    reset_n = 1'b0;
    #1;
    checks++; if (wr_vld[1] !== 1'b0 || rd_vld[1] !== 1'b0) begin failures++; $display("FAIL t6_rst_vld got wv=%0b rv=%0b exp 0 0", wr_vld[1], rd_vld[1]); end
    checks++; if (wr_id[1] !== 2'd0 || rd_id[1] !== 2'd0) begin failures++; $display("FAIL t6_rst_id got wid=%0d rid=%0d exp 0 0", wr_id[1], rd_id[1]); end
    checks++; if (drop[1] !== 16'd0 || perr[1] !== 1'b0) begin failures++; $display("FAIL t6_rst_cnt got drop=%0d err=%0b exp 0 0", drop[1], perr[1]); end
    checks++; if (rcnt[1] !== 3'd1) begin failures++; $display("FAIL t6_rst_rcnt got=%0d exp=1", rcnt[1]); end
    wr_rq[1] = 1'b0;
    rd_rq[1] = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    req_write(1, 4, lat, id);
    checks++; if (id !== 2'd1 || lat !== 1) begin failures++; $display("FAIL t6_post_rst_wr got=%0d lat=%0d exp=1 lat=1", id, lat); end
    rel_write(1);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      wr_rq[d] = 1'b0; fin_wr[d] = 1'b0; rd_rq[d] = 1'b0; fin_rd[d] = 1'b0;
    end
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);
    test_reset();
    test_latest_rotation();
    test_latest_drop();
    test_queue_order();
    test_queue_empty_read();
    test_same_cycle_and_err();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
